// File: rtl/multi_bank_memory_pkg.sv
// Shared sizing for the banked scratch RAM: default geometry and derived widths.
package multi_bank_memory_pkg;

  localparam int MBM_DATA_WIDTH     = 8;
  localparam int MBM_ADDR_WIDTH     = 4;
  localparam int MBM_NUM_BANKS      = 4;
  localparam int MBM_BANK_SEL_WIDTH = $clog2(MBM_NUM_BANKS);
  localparam int MBM_BANK_DEPTH     = 2 ** MBM_ADDR_WIDTH;

endpackage

// File: rtl/mbm_bank.sv
// One bank of the banked scratch RAM: clearable register array with a
// combinational read port; the top level registers the selected word.
module mbm_bank
  import multi_bank_memory_pkg::*;
#(
  parameter int DATA_WIDTH = MBM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MBM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // NOTE: every word must read zero after reset, so the array is built from
  // resettable flops rather than a RAM macro; no initial block is relied on.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[addr] <= din;
    end
  end

  assign rd_data = r_mem[addr];

endmodule

// File: rtl/multi_bank_memory.sv
// Banked single-port synchronous RAM with a registered read port.
// Define MULTI_BANK_MEMORY_WRITE_THROUGH_EN to forward write data to dout.
module multi_bank_memory
  import multi_bank_memory_pkg::*;
#(
  parameter int DATA_WIDTH     = MBM_DATA_WIDTH,
  parameter int ADDR_WIDTH     = MBM_ADDR_WIDTH,
  parameter int NUM_BANKS      = MBM_NUM_BANKS,
  parameter int BANK_SEL_WIDTH = $clog2(NUM_BANKS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     din,
  input  logic [BANK_SEL_WIDTH-1:0] bank_sel,
  output logic [DATA_WIDTH-1:0]     dout
);

  logic [NUM_BANKS-1:0]  w_bank_we;
  logic [DATA_WIDTH-1:0] w_rd_data [NUM_BANKS];
  logic [DATA_WIDTH-1:0] w_rd_mux;
  logic [DATA_WIDTH-1:0] r_dout;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign w_bank_we[g] = we & (bank_sel == BANK_SEL_WIDTH'(g));

    mbm_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (w_bank_we[g]),
      .addr    (addr),
      .din     (din),
      .rd_data (w_rd_data[g])
    );
  end

  // An unmatched bank_sel falls through to zero, which is what an
  // out-of-range read must return.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_sel == BANK_SEL_WIDTH'(i)) begin
        w_rd_mux = w_rd_data[i];
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
    end else if (!we) begin
      r_dout <= w_rd_mux;
    end
`ifdef MULTI_BANK_MEMORY_WRITE_THROUGH_EN
    else begin
      r_dout <= din;
    end
`endif
  end

  assign dout = r_dout;

endmodule

// File: tb/tb_multi_bank_memory.sv
// Directed self-checking bench for multi_bank_memory; honours
// MULTI_BANK_MEMORY_WRITE_THROUGH_EN when computing dout during writes.
module tb_multi_bank_memory;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [3:0] addr;
  logic [7:0] din;
  logic [1:0] bank_sel;
  logic [7:0] dout;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_dout;

  multi_bank_memory dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .addr     (addr),
    .din      (din),
    .bank_sel (bank_sel),
    .dout     (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; dout is sampled there too.
  task automatic wr(input logic [1:0] b, input logic [3:0] a, input logic [7:0] d);
    rst = 1'b0; we = 1'b1; bank_sel = b; addr = a; din = d;
    @(posedge clk); #1;
`ifdef MULTI_BANK_MEMORY_WRITE_THROUGH_EN
    exp_dout = d;
`endif
    check($sformatf("wr b%0d a%0h dout", b, a), dout, exp_dout);
  endtask

  task automatic rd(input logic [1:0] b, input logic [3:0] a, input logic [7:0] exp);
    rst = 1'b0; we = 1'b0; bank_sel = b; addr = a; din = 8'h00;
    @(posedge clk); #1;
    exp_dout = exp;
    check($sformatf("rd b%0d a%0h", b, a), dout, exp);
  endtask

  task automatic rd_all_zero(input string tag);
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 16; a++) begin
        rst = 1'b0; we = 1'b0; bank_sel = 2'(b); addr = 4'(a);
        @(posedge clk); #1;
        check($sformatf("%s b%0d a%0h", tag, b, a), dout, 8'h00);
      end
    end
    exp_dout = 8'h00;
  endtask

  initial begin
    rst = 1'b1; we = 1'b1; addr = 4'hF; din = 8'hFF; bank_sel = 2'd3;
    repeat (2) @(posedge clk);
    #1;
    check("reset dout", dout, 8'h00);
    exp_dout = 8'h00;

    rd(2'd3, 4'hF, 8'h00);
    rd_all_zero("post-reset");

    // First pass
    wr(2'd0, 4'h2, 8'hA5);
    wr(2'd1, 4'h3, 8'h5A);
    wr(2'd2, 4'h4, 8'hB3);
    wr(2'd3, 4'h5, 8'h7E);
    rd(2'd0, 4'h2, 8'hA5);
    rd(2'd1, 4'h3, 8'h5A);
    rd(2'd2, 4'h4, 8'hB3);
    rd(2'd3, 4'h5, 8'h7E);

    // Second pass, first-pass data must survive
    wr(2'd0, 4'h6, 8'hC7);
    wr(2'd1, 4'h7, 8'hD9);
    wr(2'd2, 4'h8, 8'hE2);
    wr(2'd3, 4'h9, 8'hF4);
    rd(2'd0, 4'h6, 8'hC7);
    rd(2'd1, 4'h7, 8'hD9);
    rd(2'd2, 4'h8, 8'hE2);
    rd(2'd3, 4'h9, 8'hF4);
    rd(2'd0, 4'h2, 8'hA5);
    rd(2'd3, 4'h5, 8'h7E);

    // Bank isolation at addr 2
    wr(2'd0, 4'h2, 8'hA5);
    rd(2'd1, 4'h2, 8'h00);
    rd(2'd2, 4'h2, 8'h00);
    rd(2'd3, 4'h2, 8'h00);
    rd(2'd0, 4'h2, 8'hA5);

    // Overwrite, then read-after-write on the next cycle
    rd(2'd2, 4'h4, 8'hB3);
    wr(2'd1, 4'h3, 8'h11);
    wr(2'd1, 4'h3, 8'h22);
    rd(2'd1, 4'h3, 8'h22);
    rd(2'd1, 4'h7, 8'hD9);

    // Mid-operation reset with a write presented; the write must be ignored
    rst = 1'b1; we = 1'b1; bank_sel = 2'd2; addr = 4'hC; din = 8'h99;
    @(posedge clk); #1;
    check("mid reset dout", dout, 8'h00);
    exp_dout = 8'h00;
    rd(2'd0, 4'h2, 8'h00);
    rd(2'd1, 4'h3, 8'h00);
    rd(2'd2, 4'h4, 8'h00);
    rd(2'd3, 4'h5, 8'h00);
    rd(2'd0, 4'h6, 8'h00);
    rd(2'd1, 4'h7, 8'h00);
    rd(2'd2, 4'h8, 8'h00);
    rd(2'd3, 4'h9, 8'h00);
    rd(2'd2, 4'hC, 8'h00);
    rd_all_zero("post-midreset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
